cam_pixel_capture: RTL and testbench

//  Upstream stage of the colour-detect pipeline. Receives the camera byte stream:

---
 rtl/cam_pixel_capture_if.sv | 26 ++
 rtl/cam_pixel_capture.sv | 174 +++++++++++++++++
 tb/tb_cam_pixel_capture.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_pixel_capture_if.sv
// Camera byte stream (camera -> capture) and decimated pixel stream (capture -> detector).
interface cam_byte_if;
  logic       cam_vsync;
  logic       cam_href;
  logic       cam_de;
  logic [7:0] cam_data;

  modport master(output cam_vsync, output cam_href, output cam_de, output cam_data);
  modport slave (input  cam_vsync, input  cam_href, input  cam_de, input  cam_data);
endinterface

interface pix_out_if;
  logic [11:0] pix_data;
  logic [18:0] pix_row;
  logic [18:0] pix_col;
  logic        pix_valid;
  logic        frame_start;
  logic        frame_done;
  logic        line_err;
  logic        frame_err;

  modport master(output pix_data, output pix_row, output pix_col, output pix_valid,
                 output frame_start, output frame_done, output line_err, output frame_err);
  modport slave (input  pix_data, input  pix_row, input  pix_col, input  pix_valid,
                 input  frame_start, input  frame_done, input  line_err, input  frame_err);
endinterface

// File: rtl/cam_pixel_capture.sv
// Pairs RGB444 camera bytes into pixels, decimates 2x2 and emits the output raster.
// All outputs are registered: pulses appear one clock after the input cycle that causes them.
module cam_pixel_capture #(
  parameter int SRC_WIDTH  = 640,
  parameter int SRC_HEIGHT = 480,
  parameter int IMG_WIDTH  = SRC_WIDTH / 2,
  parameter int IMG_HEIGHT = SRC_HEIGHT / 2
) (
  input  logic      clk,
  input  logic      reset,
  cam_byte_if.slave cam,
  pix_out_if.master pix
);

  localparam int BYTES = 2 * SRC_WIDTH;
  localparam int BCW   = $clog2(BYTES) + 1;
  localparam int PXW   = $clog2(SRC_WIDTH + 1);
  localparam int LNW   = $clog2(SRC_HEIGHT + 1);

  localparam logic [BCW-1:0] BYTES_C   = BCW'(BYTES);
  localparam logic [PXW-1:0] PIX_MAX   = PXW'(SRC_WIDTH);
  localparam logic [LNW-1:0] LINE_MAX  = LNW'(SRC_HEIGHT);
  localparam logic [PXW-1:0] PIX_LAST  = PXW'(2 * (IMG_WIDTH - 1));
  localparam logic [LNW-1:0] LINE_LAST = LNW'(2 * (IMG_HEIGHT - 1));

  typedef enum logic [1:0] {SYNC, LINE_WAIT, BYTE_HI, BYTE_LO} state_t;

  state_t         state_q, state_d;
  logic           vsync_q, href_q;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d, byte_cnt_inc;
  logic [PXW-1:0] src_pix_q, src_pix_d;
  logic [LNW-1:0] src_line_q, src_line_d;
  logic [3:0]     red_q, red_d;
  logic           done_seen_q, done_seen_d;
  logic [11:0]    pix_data_q, pix_data_d;
  logic [18:0]    pix_row_q, pix_row_d, pix_col_q, pix_col_d;
  logic           pix_valid_q, pix_valid_d;
  logic           frame_start_q, frame_start_d;
  logic           frame_done_q, frame_done_d;
  logic           line_err_q, line_err_d;
  logic           frame_err_q, frame_err_d;

  logic vsync_fall, vsync_rise, href_rise, href_fall, byte_ok, emit_ok, last_pix;

  assign vsync_fall   = vsync_q & ~cam.cam_vsync;
  assign vsync_rise   = ~vsync_q & cam.cam_vsync;
  assign href_rise    = ~href_q & cam.cam_href;
  assign href_fall    = href_q & ~cam.cam_href;
  // A strobe on the cycle href drops still belongs to the closing line.
  assign byte_ok      = cam.cam_de & (cam.cam_href | href_q);
  assign byte_cnt_inc = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 1'b1;
  assign emit_ok      = ~src_line_q[0] & ~src_pix_q[0] &
                        (src_pix_q < PIX_MAX) & (src_line_q < LINE_MAX);
  assign last_pix     = (src_pix_q == PIX_LAST) & (src_line_q == LINE_LAST);

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    src_pix_d     = src_pix_q;
    src_line_d    = src_line_q;
    red_d         = red_q;
    done_seen_d   = done_seen_q;
    pix_data_d    = pix_data_q;
    pix_row_d     = pix_row_q;
    pix_col_d     = pix_col_q;
    pix_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    line_err_d    = 1'b0;
    frame_err_d   = 1'b0;

    if (vsync_fall) begin
      frame_start_d = 1'b1;
      src_line_d    = '0;
      src_pix_d     = '0;
      byte_cnt_d    = '0;
      done_seen_d   = 1'b0;
      state_d       = LINE_WAIT;
    end else if (vsync_rise) begin
      if (state_q != SYNC) begin
        frame_err_d = ~done_seen_q;
        state_d     = SYNC;
      end
    end else begin
      case (state_q)
        SYNC: ;
        LINE_WAIT: begin
          if (href_rise) begin
            byte_cnt_d = '0;
            src_pix_d  = '0;
            state_d    = BYTE_HI;
          end
        end
        BYTE_HI, BYTE_LO: begin
          if (byte_ok) begin
            byte_cnt_d = byte_cnt_inc;
            if (state_q == BYTE_HI) begin
              red_d   = cam.cam_data[3:0];
              state_d = BYTE_LO;
            end else begin
              state_d = BYTE_HI;
              if (emit_ok) begin
                pix_valid_d = 1'b1;
                pix_data_d  = {red_q, cam.cam_data};
                pix_row_d   = 19'(src_line_q >> 1);
                pix_col_d   = 19'(src_pix_q >> 1);
                if (last_pix) begin
                  frame_done_d = 1'b1;
                  done_seen_d  = 1'b1;
                end
              end
              if (src_pix_q != PIX_MAX) src_pix_d = src_pix_q + 1'b1;
            end
          end
          // Line close: a dangling first byte is simply dropped with the state change.
          if (href_fall) begin
            line_err_d = (byte_cnt_d != BYTES_C);
            if (src_line_q != LINE_MAX) src_line_d = src_line_q + 1'b1;
            state_d = LINE_WAIT;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SYNC;
      vsync_q       <= cam.cam_vsync;
      href_q        <= cam.cam_href;
      byte_cnt_q    <= '0;
      src_pix_q     <= '0;
      src_line_q    <= '0;
      red_q         <= '0;
      done_seen_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_row_q     <= '0;
      pix_col_q     <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= cam.cam_vsync;
      href_q        <= cam.cam_href;
      byte_cnt_q    <= byte_cnt_d;
      src_pix_q     <= src_pix_d;
      src_line_q    <= src_line_d;
      red_q         <= red_d;
      done_seen_q   <= done_seen_d;
      pix_data_q    <= pix_data_d;
      pix_row_q     <= pix_row_d;
      pix_col_q     <= pix_col_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign pix.pix_data    = pix_data_q;
  assign pix.pix_row     = pix_row_q;
  assign pix.pix_col     = pix_col_q;
  assign pix.pix_valid   = pix_valid_q;
  assign pix.frame_start = frame_start_q;
  assign pix.frame_done  = frame_done_q;
  assign pix.line_err    = line_err_q;
  assign pix.frame_err   = frame_err_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Randomised camera stream against a frame/line/byte-index model that schedules expected outputs per cycle.
module tb_cam_pixel_capture;
  localparam int W  = 16;
  localparam int H  = 8;
  localparam int IW = W / 2;
  localparam int IH = H / 2;
  localparam int K_PIX = 0, K_FS = 1, K_FD = 2, K_LE = 3, K_FE = 4, K_RST = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cam_byte_if cam();
  pix_out_if  pix();

  cam_pixel_capture #(.SRC_WIDTH(W), .SRC_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .cam(cam), .pix(pix)
  );

  typedef struct {
    bit pv, fs, fd, le, fe, rst;
    logic [11:0] dat;
    int row, col;
  } exp_t;

  exp_t expq[int];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  bit active = 0, done_f = 0, vs_cur = 1;
  int line = 0;
  int cnt_pix = 0, cnt_fd = 0, cnt_fs = 0, cnt_le = 0, cnt_fe = 0, row0_cnt = 0;
  logic [11:0] r3c7 = '0;

  task automatic chk(string name, int act, int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cycle %0d",
               name, act, act, exp_v, exp_v, cyc);
    end
  endtask

  function automatic exp_t get_exp(int c);
    exp_t e;
    e = '{default: 0};
    if (expq.exists(c)) e = expq[c];
    return e;
  endfunction

  task automatic sched(int k, logic [11:0] d = 12'h0, int r = 0, int c = 0);
    exp_t e = get_exp(cyc + 1);
    case (k)
      K_PIX: begin e.pv = 1; e.dat = d; e.row = r; e.col = c; end
      K_FS:  e.fs = 1;
      K_FD:  e.fd = 1;
      K_LE:  e.le = 1;
      K_FE:  e.fe = 1;
      default: e.rst = 1;
    endcase
    expq[cyc + 1] = e;
  endtask

  // Compare process: every output, every cycle, against the scheduled expectations.
  initial begin
    exp_t e;
    logic [11:0] hd;
    int hr, hc;
    hd = '0; hr = 0; hc = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e = get_exp(cyc);
      if (e.rst) begin hd = '0; hr = 0; hc = 0; end
      if (e.pv)  begin hd = e.dat; hr = e.row; hc = e.col; end
      chk("pix_valid",   pix.pix_valid,   e.pv);
      chk("frame_start", pix.frame_start, e.fs);
      chk("frame_done",  pix.frame_done,  e.fd);
      chk("line_err",    pix.line_err,    e.le);
      chk("frame_err",   pix.frame_err,   e.fe);
      chk("pix_data",    pix.pix_data,    hd);
      chk("pix_row",     pix.pix_row,     hr);
      chk("pix_col",     pix.pix_col,     hc);
      if (pix.pix_valid) begin
        cnt_pix++;
        if (pix.pix_row == 0) row0_cnt++;
        if (pix.pix_row == 3 && pix.pix_col == 7) r3c7 = pix.pix_data;
      end
      if (pix.frame_done)  cnt_fd++;
      if (pix.frame_start) cnt_fs++;
      if (pix.line_err)    cnt_le++;
      if (pix.frame_err)   cnt_fe++;
      expq.delete(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(bit rs, bit h, bit de, logic [7:0] d);
    reset         = rs;
    cam.cam_vsync = vs_cur;
    cam.cam_href  = h;
    cam.cam_de    = de;
    cam.cam_data  = d;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      put(0, 0, 1'($urandom_range(1)), 8'($urandom));
      tick();
    end
  endtask

  task automatic vsync_fall();
    vs_cur = 0;
    put(0, 0, 0, 8'h00);
    sched(K_FS);
    active = 1; line = 0; done_f = 0;
    tick();
  endtask

  task automatic vsync_rise();
    vs_cur = 1;
    put(0, 0, 0, 8'h00);
    if (active && !done_f) sched(K_FE);
    active = 0;
    tick();
  endtask

  // mode 0: constant (0x0A,0x5C); 1: ramp (pixel index, line index); 2: random.
  task automatic send_line(int nbytes, int mode, bit coinc, int rst_at);
    logic [3:0] r;
    logic [7:0] b;
    int p;
    bit last, h;
    r = 4'h0;
    put(0, 1, 0, 8'h00);
    tick();
    for (int i = 0; i < nbytes; i++) begin
      if ($urandom_range(3) == 0) begin
        put(0, 1, 0, 8'($urandom));
        tick();
      end
      p = i / 2;
      case (mode)
        0:       b = (i % 2 == 0) ? 8'h0A : 8'h5C;
        1:       b = (i % 2 == 0) ? {4'($urandom), 4'(p)} : 8'(line);
        default: b = 8'($urandom);
      endcase
      last = (i == nbytes - 1);
      h    = !(coinc && last);
      if (i == rst_at) begin
        active = 0;
        sched(K_RST);
      end
      put(i == rst_at, h, 1, b);
      if (active && (i % 2 == 1) && (line % 2 == 0) && line < H && (p % 2 == 0) && p < W) begin
        sched(K_PIX, {r, b}, line / 2, p / 2);
        if (line / 2 == IH - 1 && p / 2 == IW - 1) begin
          sched(K_FD);
          done_f = 1;
        end
      end
      if (i % 2 == 0) r = b[3:0];
      if (last && coinc && active && nbytes != 2 * W) sched(K_LE);
      tick();
    end
    if (!coinc) begin
      put(0, 0, 0, 8'($urandom));
      if (active && nbytes != 2 * W) sched(K_LE);
      tick();
    end
    if (active) line++;
    idle($urandom_range(1, 3));
  endtask

  task automatic run_frame(int mode);
    vsync_fall();
    idle(2);
    for (int l = 0; l < H; l++) send_line(2 * W, mode, 0, -1);
    idle(2);
    vsync_rise();
    idle(3);
  endtask

  task automatic clear_counts();
    cnt_pix = 0; cnt_fd = 0; cnt_fs = 0; cnt_le = 0; cnt_fe = 0; row0_cnt = 0;
  endtask

  initial begin
    vs_cur = 1;
    put(1, 0, 0, 8'h00);
    sched(K_RST);
    tick();
    idle(3);

    // Bytes before the first frame start are ignored.
    send_line(2 * W, 2, 0, -1);
    idle(2);

    // Constant pair frame.
    clear_counts();
    run_frame(0);
    chk("t1_pix_count", cnt_pix, 32);
    chk("t1_frame_done", cnt_fd, 1);
    chk("t1_frame_start", cnt_fs, 1);
    chk("t1_line_err", cnt_le, 0);
    chk("t1_frame_err", cnt_fe, 0);
    chk("t1_held_data", pix.pix_data, 12'hA5C);
    chk("t1_held_row", pix.pix_row, 3);
    chk("t1_held_col", pix.pix_col, 7);

    // Ramp frame.
    clear_counts();
    run_frame(1);
    chk("t2_r3c7", r3c7, 12'hE06);
    chk("t2_pix_count", cnt_pix, 32);

    // Short, long and coincident-final-byte lines.
    clear_counts();
    vsync_fall();
    idle(2);
    send_line(2 * W - 3, 2, 0, -1);
    send_line(2 * W, 2, 0, -1);
    send_line(2 * W + 2, 2, 0, -1);
    for (int l = 3; l < 6; l++) send_line(2 * W, 2, 0, -1);
    send_line(2 * W, 2, 1, -1);
    send_line(2 * W, 2, 0, -1);
    idle(2);
    vsync_rise();
    idle(3);
    chk("t3_row0_count", row0_cnt, 7);
    chk("t3_line_err", cnt_le, 2);
    chk("t3_pix_count", cnt_pix, 31);
    chk("t3_frame_done", cnt_fd, 1);

    // Truncated frame, then a full one.
    clear_counts();
    vsync_fall();
    idle(2);
    for (int l = 0; l < 3; l++) send_line(2 * W, 2, 0, -1);
    vsync_rise();
    idle(3);
    chk("t4_frame_err", cnt_fe, 1);
    chk("t4_frame_done", cnt_fd, 0);
    clear_counts();
    run_frame(2);
    chk("t4_full_done", cnt_fd, 1);
    chk("t4_full_ferr", cnt_fe, 0);
    chk("t4_full_pix", cnt_pix, 32);

    // Reset pulse mid-frame while bytes keep flowing.
    clear_counts();
    vsync_fall();
    idle(2);
    for (int l = 0; l < 3; l++) send_line(2 * W, 2, 0, -1);
    send_line(2 * W, 2, 0, 10);
    for (int l = 4; l < H; l++) send_line(2 * W, 2, 0, -1);
    vsync_rise();
    idle(3);
    chk("t5_pix_count", cnt_pix, 16);
    chk("t5_frame_done", cnt_fd, 0);
    chk("t5_frame_err", cnt_fe, 0);
    chk("t5_zero_data", pix.pix_data, 0);
    chk("t5_zero_row", pix.pix_row, 0);
    clear_counts();
    run_frame(2);
    chk("t5_next_done", cnt_fd, 1);
    chk("t5_next_pix", cnt_pix, 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
